// File: rtl/rat_intr_ctrl_if.sv
// Port-ID I/O bus between the RAT MCU wrapper and the interrupt controller.
// The MCU drives the ID, write data and strobe; the controller returns the read data and hit flag.
interface rat_intr_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;
  logic       IN_HIT;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_DATA,
    input  IN_HIT
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_DATA,
    output IN_HIT
  );
endinterface

// File: rtl/rat_intr_ctrl.sv
// RAT MCU interrupt controller: synchronises edge events, latches them as pending flags,
// masks them and raises INTR for the lowest-index request until the MCU acknowledges it.
module rat_intr_ctrl #(
  parameter int unsigned N_SRC       = 4,
  parameter logic [7:0]  MASK_ID     = 8'h60,
  parameter logic [7:0]  STATUS_ID   = 8'h61,
  parameter logic [7:0]  VECTOR_ID   = 8'h62,
  parameter logic [7:0]  ACK_ID      = 8'h63,
  parameter int unsigned INTR_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] SRC,
  rat_intr_ctrl_if.slave   bus,
  output logic             INTR,
  output logic             IN_SERVICE
);

  localparam int unsigned CntW = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             intr_q, intr_d;
  logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [N_SRC-1:0] pending_q, mask_q;
  logic [N_SRC-1:0] rise, req, ack_clr;
  logic [2:0]       winner;
  logic             mask_wr, ack_wr;

  assign mask_wr = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
  assign ack_wr  = bus.IO_STRB && (bus.PORT_ID == ACK_ID);
  assign ack_clr = ack_wr ? bus.OUT_PORT[N_SRC-1:0] : '0;
  assign rise    = sync2_q & ~sync3_q;
  assign req     = pending_q & mask_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      sync1_q   <= SRC;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      // A new event on the same edge as its ack keeps the flag set
      pending_q <= (pending_q & ~ack_clr) | rise;
      if (mask_wr) begin
        mask_q <= bus.OUT_PORT[N_SRC-1:0];
      end
    end
  end

  // Fixed priority: lowest set index wins
  always_comb begin
    winner = 3'd0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    intr_d  = intr_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          idx_d   = winner;
          cnt_d   = CntW'(INTR_CYCLES - 1);
          intr_d  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (cnt_q == '0) begin
          intr_d  = 1'b0;
          state_d = StService;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StService: begin
        // Only an ack of the in-service source releases the FSM
        if (ack_wr && bus.OUT_PORT[idx_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      intr_q  <= intr_d;
    end
  end

  assign INTR       = intr_q;
  assign IN_SERVICE = (state_q != StIdle);

  logic [7:0] mask_ext, pending_ext;

  always_comb begin
    mask_ext                 = '0;
    mask_ext[N_SRC-1:0]      = mask_q;
    pending_ext              = '0;
    pending_ext[N_SRC-1:0]   = pending_q;
    bus.IN_DATA              = 8'h00;
    bus.IN_HIT               = 1'b0;
    case (bus.PORT_ID)
      MASK_ID: begin
        bus.IN_DATA = mask_ext;
        bus.IN_HIT  = 1'b1;
      end
      STATUS_ID: begin
        bus.IN_DATA = pending_ext;
        bus.IN_HIT  = 1'b1;
      end
      VECTOR_ID: begin
        bus.IN_DATA = IN_SERVICE ? {1'b1, 4'b0000, idx_q} : 8'h00;
        bus.IN_HIT  = 1'b1;
      end
      default: begin
        bus.IN_DATA = 8'h00;
        bus.IN_HIT  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: directed scenarios plus a randomized run against a
// request/service reference model driven from the same cycle ticks.
module tb_rat_intr_ctrl;

  localparam int INTR_CYCLES = 2;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] SRC;
  logic       INTR;
  logic       IN_SERVICE;

  int checks = 0;
  int errors = 0;

  rat_intr_ctrl_if bus ();

  rat_intr_ctrl #(
    .N_SRC      (4),
    .MASK_ID    (8'h60),
    .STATUS_ID  (8'h61),
    .VECTOR_ID  (8'h62),
    .ACK_ID     (8'h63),
    .INTR_CYCLES(INTR_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SRC       (SRC),
    .bus       (bus),
    .INTR      (INTR),
    .IN_SERVICE(IN_SERVICE)
  );

  always #10 CLK = ~CLK;

  // Reference model: pending set, mask, and the request being serviced
  logic [3:0] m_pend, m_mask;
  logic [3:0] hist [3];   // SRC as sampled 1, 2, 3 edges ago
  bit         m_busy;
  int         m_left;     // INTR cycles still to come for the current request
  int         m_idx;

  task automatic model_reset();
    m_pend = 4'h0; m_mask = 4'h0; m_busy = 0; m_left = 0; m_idx = 0;
    hist[0] = 4'h0; hist[1] = 4'h0; hist[2] = 4'h0;
  endtask

  function automatic int lowest(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] exp_rd(logic [7:0] id);
    case (id)
      8'h60:   return {4'h0, m_mask};
      8'h61:   return {4'h0, m_pend};
      8'h62:   return m_busy ? (8'h80 | 8'(m_idx)) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    logic [3:0] ev, req, ack;
    @(posedge CLK);
    // An event is a level seen high two edges ago after being low three edges ago
    ev  = hist[1] & ~hist[2];
    ack = (bus.IO_STRB && bus.PORT_ID == 8'h63) ? bus.OUT_PORT[3:0] : 4'h0;
    req = m_pend & m_mask;
    if (!m_busy) begin
      if (req != 4'h0) begin
        m_busy = 1; m_idx = lowest(req); m_left = INTR_CYCLES;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else if (ack[m_idx]) begin
      m_busy = 0;
    end
    m_pend = (m_pend & ~ack) | ev;
    if (bus.IO_STRB && bus.PORT_ID == 8'h60) m_mask = bus.OUT_PORT[3:0];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = SRC;
    #1;
  endtask

  task automatic wr(logic [7:0] id, logic [7:0] data);
    bus.PORT_ID = id; bus.OUT_PORT = data; bus.IO_STRB = 1'b1;
    tick();
    bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
  endtask

  task automatic rd(logic [7:0] id, output logic [7:0] data);
    bus.PORT_ID = id;
    #1;
    data = bus.IN_DATA;
  endtask

  task automatic idle_ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    wr(8'h60, 8'h01);
    SRC = 4'h1;
    idle_ticks(4);
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL reset_pre_intr: got %b want 1", INTR); end
    #2 RESET_N = 1'b0; model_reset();
    #1;
    checks++;
    if (INTR !== 1'b0) begin errors++; $display("FAIL reset_intr_async: got %b want 0", INTR); end
    checks++;
    if (IN_SERVICE !== 1'b0) begin
      errors++; $display("FAIL reset_in_service: got %b want 0", IN_SERVICE);
    end
    SRC = 4'h0;
    #1 RESET_N = 1'b1;
    rd(8'h61, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", d); end
    rd(8'h60, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", d); end
    rd(8'h62, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h want 00", d); end
    idle_ticks(3);
  endtask

  task automatic test_single();
    logic [7:0] d;
    wr(8'h60, 8'h01);
    SRC = 4'h1;
    idle_ticks(3);
    rd(8'h61, d); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL single_status_k2: got %h want 01", d); end
    checks++;
    if (INTR !== 1'b0) begin errors++; $display("FAIL single_intr_k2: got %b want 0", INTR); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (INTR !== (i < 2)) begin
        errors++; $display("FAIL single_intr_cycle%0d: got %b want %b", i, INTR, i < 2);
      end
    end
    rd(8'h62, d); checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL single_vector: got %h want 80", d); end
    wr(8'h63, 8'h01);
    checks++;
    if (IN_SERVICE !== 1'b0) begin
      errors++; $display("FAIL single_ack_idle: got %b want 0", IN_SERVICE);
    end
    rd(8'h61, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL single_status_ack: got %h want 00", d); end
    SRC = 4'h0;
    idle_ticks(4);
    checks++;
    if (INTR !== 1'b0 || IN_SERVICE !== 1'b0) begin
      errors++; $display("FAIL single_no_refire: got intr=%b svc=%b want 0 0", INTR, IN_SERVICE);
    end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    wr(8'h60, 8'h0F);
    SRC = 4'b1010;
    idle_ticks(4);
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL prio_intr1: got %b want 1", INTR); end
    rd(8'h62, d); checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL prio_vector1: got %h want 81", d); end
    idle_ticks(2);
    wr(8'h63, 8'h02);
    checks++;
    if (IN_SERVICE !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b want 0", IN_SERVICE); end
    tick();
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL prio_intr2: got %b want 1", INTR); end
    rd(8'h62, d); checks++;
    if (d !== 8'h83) begin errors++; $display("FAIL prio_vector2: got %h want 83", d); end
    idle_ticks(2);
    wr(8'h63, 8'h08);
    SRC = 4'h0;
    rd(8'h61, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL prio_status_end: got %h want 00", d); end
    idle_ticks(3);
  endtask

  task automatic test_masking();
    logic [7:0] d;
    wr(8'h60, 8'h00);
    SRC = 4'b0100;
    idle_ticks(4);
    rd(8'h61, d); checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL mask_status: got %h want 04", d); end
    checks++;
    if (INTR !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", INTR); end
    wr(8'h60, 8'h04);
    checks++;
    if (INTR !== 1'b0) begin errors++; $display("FAIL mask_write_edge: got %b want 0", INTR); end
    tick();
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL mask_unmask_intr: got %b want 1", INTR); end
    idle_ticks(2);
    wr(8'h63, 8'h04);
    SRC = 4'h0;
    idle_ticks(3);
  endtask

  task automatic test_collision();
    logic [7:0] d;
    wr(8'h60, 8'h00);
    SRC = 4'h1;
    idle_ticks(2);
    wr(8'h63, 8'h01);
    rd(8'h61, d); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL collision_set_wins: got %h want 01", d); end
    wr(8'h63, 8'h01);
    rd(8'h61, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL collision_clear: got %h want 00", d); end
    SRC = 4'h0;
    idle_ticks(3);
  endtask

  task automatic test_wrong_ack();
    logic [7:0] d;
    wr(8'h60, 8'h02);
    SRC = 4'b0010;
    idle_ticks(4);
    // Ack during the request only clears the flag
    wr(8'h63, 8'h02);
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL wack_req_hold: got %b want 1", INTR); end
    rd(8'h61, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL wack_req_status: got %h want 00", d); end
    tick();
    checks++;
    if (INTR !== 1'b0 || IN_SERVICE !== 1'b1) begin
      errors++; $display("FAIL wack_service: got intr=%b svc=%b want 0 1", INTR, IN_SERVICE);
    end
    wr(8'h63, 8'h01);
    checks++;
    if (IN_SERVICE !== 1'b1) begin errors++; $display("FAIL wack_wrong: got %b want 1", IN_SERVICE); end
    rd(8'h62, d); checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL wack_vector: got %h want 81", d); end
    wr(8'h63, 8'h02);
    checks++;
    if (IN_SERVICE !== 1'b0) begin errors++; $display("FAIL wack_right: got %b want 0", IN_SERVICE); end
    SRC = 4'h0;
    idle_ticks(3);
  endtask

  task automatic test_random();
    logic [7:0] ids [5] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h55};
    logic [7:0] id;
    logic [3:0] s;
    int r;
    for (int c = 0; c < 600; c++) begin
      s = SRC;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) s[b] = ~s[b];
      SRC = s;
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        bus.PORT_ID = 8'h60; bus.OUT_PORT = 8'($urandom); bus.IO_STRB = 1'b1;
      end else if (r <= 4) begin
        bus.PORT_ID = 8'h63; bus.IO_STRB = 1'b1;
        bus.OUT_PORT = (m_busy && r != 4) ? 8'(1 << m_idx) : 8'($urandom);
      end else begin
        id = ids[$urandom_range(0, 4)];
        bus.PORT_ID = id; bus.IO_STRB = 1'b0; bus.OUT_PORT = 8'($urandom);
        #1;
        checks++;
        if (bus.IN_DATA !== exp_rd(id) || bus.IN_HIT !== (id >= 8'h60 && id <= 8'h62)) begin
          errors++;
          $display("FAIL rand_read id=%h: got %h/%b want %h/%b", id, bus.IN_DATA, bus.IN_HIT,
                   exp_rd(id), (id >= 8'h60 && id <= 8'h62));
        end
      end
      tick();
      bus.IO_STRB = 1'b0;
      checks++;
      if (INTR !== (m_left > 0) || IN_SERVICE !== m_busy) begin
        errors++;
        $display("FAIL rand_cycle%0d: got intr=%b svc=%b want %b %b", c, INTR, IN_SERVICE,
                 m_left > 0, m_busy);
      end
    end
    bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
  endtask

  initial begin
    SRC = 4'h0;
    bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    #22 RESET_N = 1'b1;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_collision();
    test_wrong_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/rat_intr_ctrl.md
# rat_intr_ctrl

Interrupt controller for the RAT MCU. It collects up to 8 asynchronous event sources, latches their rising edges as pending flags, masks them, and arbitrates them onto the MCU's single INTR input by fixed priority. It sits in the wrapper on the port-ID I/O bus next to the switch and LED/seven-segment ports, and runs on the divided MCU clock. The MCU configures it, reads the active vector and acknowledges service through port writes and reads.

## Interface
- N_SRC, 4: number of interrupt sources, legal range 1..8.
- MASK_ID, 8'h60: read/write port for the mask register; a 1 bit enables that source.
- STATUS_ID, 8'h61: read-only port returning the pending flags.
- VECTOR_ID, 8'h62: read-only port returning the in-service vector.
- ACK_ID, 8'h63: write-only port; write 1 to a bit to clear that pending flag.
- INTR_CYCLES, 2: number of cycles INTR is held high per request, minimum 1.
- CLK, input, 1: MCU clock, the divided SlowCLK. All state updates on its rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- SRC, input, N_SRC: asynchronous event inputs; a rising edge is an event.
- PORT_ID, input, 8: MCU port ID.
- OUT_PORT, input, 8: MCU output data.
- IO_STRB, input, 1: MCU write strobe; a write occurs when high at a rising edge of CLK.
- IN_DATA, output, 8: read data, combinational from PORT_ID.
- IN_HIT, output, 1: high when PORT_ID equals MASK_ID, STATUS_ID or VECTOR_ID; the wrapper muxes IN_DATA onto the MCU input port when IN_HIT is high.
- INTR, output, 1: registered interrupt request to the MCU.
- IN_SERVICE, output, 1: high in the REQ and SERVICE states.

## Operation
- Input synchronizer: each SRC bit passes through sync1, then sync2, then sync3 flops. The rise term is sync2 & ~sync3.
- Pending register: pending <= (pending & ~ack_clr) | rise.
  - Set wins when set and clear hit the same bit in the same cycle.
  - ack_clr is OUT_PORT[N_SRC-1:0] when IO_STRB is high and PORT_ID equals ACK_ID.
- Mask register: loaded from OUT_PORT[N_SRC-1:0] on a write to MASK_ID.
  - Bits at N_SRC and above are ignored on write and read back as 0.
- Requests: req = pending & mask. The winner is the lowest set index.
- State machine:
  - IDLE: when req != 0, latch the winner index into `idx`, load the hold counter with INTR_CYCLES-1, set INTR=1 and go to REQ.
  - REQ: INTR=1. Decrement the counter. When the counter is 0, set INTR=0 and go to SERVICE.
  - SERVICE: INTR=0. Wait for an ACK write with bit `idx` set, then go to IDLE.
  - From IDLE, the next request can be raised no earlier than the following cycle.
- An ACK write in REQ that clears bit `idx` clears the pending flag only. The FSM still finishes REQ, then waits in SERVICE for a further ACK of bit `idx`.
- Mask or pending changes during REQ or SERVICE never alter `idx` or abort the sequence.
- Read data:
  - MASK_ID returns the mask, zero-extended to 8 bits.
  - STATUS_ID returns the pending flags, zero-extended to 8 bits.
  - VECTOR_ID returns {1'b1, 4'b0, idx[2:0]} when IN_SERVICE is high, and 8'h00 otherwise.
  - Any other PORT_ID returns 8'h00 with IN_HIT low.
- Writes to MASK_ID and ACK_ID in the same cycle are impossible, because PORT_ID is a single value.

## Timing
- Reset values: sync flops, pending, mask, state=IDLE, counter, idx, INTR and IN_SERVICE are all 0.
- Reset acts immediately and asynchronously, including mid-REQ: INTR falls without waiting for a clock edge.
- Event latency, with the SRC rise sampled at edge k:
  - sync1 at k, sync2 at k+1, sync3 and the pending bit at k+2.
  - With the mask bit set and the FSM in IDLE, INTR is high after edge k+3.
- INTR is high for exactly INTR_CYCLES cycles per request.
- After an ACK write at edge m in SERVICE, the FSM is in IDLE after m. If a request is still outstanding, INTR is high again after m+1.
- A SRC input held high produces one event only. The next event needs a low level for at least 2 CLK cycles.
- Writes take effect at the strobed edge: a mask written at edge m gates req from the cycle after m.

## Test plan
- Reset: RESET_N low mid-REQ -> INTR=0 at once; STATUS, MASK and VECTOR all read 8'h00 afterwards.
- Single event: mask=8'h01, SRC[0] rises -> INTR high after 4 edges for 2 cycles; VECTOR=8'h80; STATUS=8'h01; ACK write 8'h01 -> IDLE, STATUS=8'h00, no re-fire.
- Priority: SRC[3] and SRC[1] rise together with mask=8'h0F -> VECTOR=8'h81; after ACK 8'h02, a second INTR fires with VECTOR=8'h83.
- Masking: mask=8'h00, SRC[2] rises -> STATUS=8'h04 and INTR stays 0; then write mask=8'h04 -> INTR high 1 cycle after the write edge.
- Set/clear collision: ACK 8'h01 lands on the same edge that pending[0] sets -> STATUS bit 0 stays 1.
- Wrong ACK: in SERVICE with idx=1, write ACK 8'h01 -> still IN_SERVICE; write ACK 8'h02 -> IDLE.
